// File: rtl/lpc_sniffer_pkg.sv
// Shared definitions for the LPC sniffer: sequencer states, frame header bytes
// and the byte layout of a decoded transaction record.
package lpc_sniffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OVF_SNAP,
        ST_RD,
        ST_LOAD,
        ST_SEND
    } seq_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] OVF_BYTE  = 8'hAF;

    // Record layout, byte 0 is transmitted first (most significant in fifo_data).
    localparam int REC_BYTES     = 6;
    localparam int REC_HDR_BYTE  = 0;  // {cycle_type[3:0], dir, 3'b0}
    localparam int REC_ADDR_BYTE = 1;  // address[31:0], bytes 1..4
    localparam int REC_DATA_BYTE = 5;

    function automatic logic [8*REC_BYTES-1:0] pack_record(
        input logic [3:0]  cycle_type,
        input logic        dir,
        input logic [31:0] addr,
        input logic [7:0]  data
    );
        logic [8*REC_BYTES-1:0] rec;
        rec = '0;
        rec[8*(REC_BYTES-1-REC_HDR_BYTE) +: 8]  = {cycle_type, dir, 3'b000};
        rec[8*(REC_BYTES-4-REC_ADDR_BYTE) +: 32] = addr;
        rec[8*(REC_BYTES-1-REC_DATA_BYTE) +: 8] = data;
        return rec;
    endfunction

endpackage

// File: rtl/lpc_uart_sequencer_if.sv
// Record FIFO read side and UART TX byte handshake, as seen by the sequencer.
interface lpc_uart_sequencer_if #(
    parameter int RECORD_BYTES = 6
);
    logic                      fifo_empty;
    logic                      fifo_read;
    logic [8*RECORD_BYTES-1:0] fifo_data;
    logic                      uart_valid;
    logic                      uart_ready;
    logic [7:0]                uart_data;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read,
        output uart_valid,
        output uart_data,
        input  uart_ready
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read,
        input  uart_valid,
        input  uart_data,
        output uart_ready
    );
endinterface

// File: rtl/lpc_frame_shifter.sv
// Byte shifter for one outgoing frame: loads a left-aligned frame, presents the
// head byte and advances on each accepted byte.
module lpc_frame_shifter #(
    parameter int FRAME_BYTES = 7,
    parameter int CNT_W       = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [8*FRAME_BYTES-1:0] load_data,
    input  logic [CNT_W-1:0]         load_rem,
    input  logic                     advance,
    output logic [7:0]               head,
    output logic                     last
);

    logic [8*FRAME_BYTES-1:0] shreg;
    logic [CNT_W-1:0]         rem;  // bytes still to follow the head byte

    // NOTE: state registers use <= only, so every flop samples pre-edge values;
    // combinational blocks use = .
    // NOTE: the datapath register is reset as well, because uart_data must read
    // zero out of reset and after an abandoned frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            rem   <= '0;
        end else if (load) begin
            shreg <= load_data;
            rem   <= load_rem;
        end else if (advance) begin
            shreg <= {shreg[8*FRAME_BYTES-9:0], 8'h00};
            if (rem != '0) rem <= rem - 1'b1;
        end
    end

    assign head = shreg[8*FRAME_BYTES-1 -: 8];
    assign last = (rem == '0);

endmodule

// File: rtl/lpc_uart_sequencer.sv
// Drains LPC records into A5-framed UART byte frames and injects AF-framed
// overflow markers carrying a saturating dropped-record count.
module lpc_uart_sequencer #(
    parameter int         RECORD_BYTES = 6,
    parameter logic [7:0] SYNC_BYTE    = lpc_sniffer_pkg::SYNC_BYTE,
    parameter logic [7:0] OVF_BYTE     = lpc_sniffer_pkg::OVF_BYTE,
    parameter int         DROP_CNT_W   = 16
) (
    input  logic                        ext_clock,
    input  logic                        lpc_reset,
    lpc_uart_sequencer_if.master        bus,
    input  logic                        drop_pulse,
    output logic                        overflow_pending,
    output logic                        busy
);
    import lpc_sniffer_pkg::*;

    localparam int DROP_BYTES  = DROP_CNT_W / 8;
    localparam int PAYLOAD_MAX = (RECORD_BYTES > DROP_BYTES) ? RECORD_BYTES : DROP_BYTES;
    localparam int FRAME_BYTES = PAYLOAD_MAX + 1;
    localparam int CNT_W       = $clog2(PAYLOAD_MAX + 1);
    localparam logic [CNT_W-1:0] REC_REM = CNT_W'(RECORD_BYTES);
    localparam logic [CNT_W-1:0] OVF_REM = CNT_W'(DROP_BYTES);

    seq_state_e               state, state_next;
    logic [DROP_CNT_W-1:0]    drop_cnt, drop_cnt_next;
    logic                     rd_req;
    logic                     load;
    logic [8*FRAME_BYTES-1:0] load_data;
    logic [CNT_W-1:0]         load_rem;
    logic                     send;
    logic                     accept;
    logic                     last;
    logic [7:0]               head;

    always_ff @(posedge ext_clock or negedge lpc_reset) begin
        if (!lpc_reset) state <= ST_IDLE;
        else            state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        rd_req     = 1'b0;
        load       = 1'b0;
        load_data  = '0;
        load_rem   = '0;
        send       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (drop_cnt != '0) begin
                    state_next = ST_OVF_SNAP;
                end else if (!bus.fifo_empty) begin
                    rd_req     = 1'b1;
                    state_next = ST_RD;
                end
            end
            ST_OVF_SNAP: begin
                load = 1'b1;
                load_data[8*FRAME_BYTES-1 -: 8*(DROP_BYTES+1)] = {OVF_BYTE, drop_cnt};
                load_rem   = OVF_REM;
                state_next = ST_SEND;
            end
            ST_RD: state_next = ST_LOAD;
            ST_LOAD: begin
                load = 1'b1;
                load_data[8*FRAME_BYTES-1 -: 8*(RECORD_BYTES+1)] = {SYNC_BYTE, bus.fifo_data};
                load_rem   = REC_REM;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                send = 1'b1;
                if (accept && last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The snapshot cycle restarts the count from the pulse that lands in it.
    always_comb begin
        drop_cnt_next = drop_cnt;
        if (state == ST_OVF_SNAP)
            drop_cnt_next = drop_pulse ? DROP_CNT_W'(1) : '0;
        else if (drop_pulse && (drop_cnt != '1))
            drop_cnt_next = drop_cnt + 1'b1;
    end

    always_ff @(posedge ext_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            drop_cnt         <= '0;
            overflow_pending <= 1'b0;
        end else begin
            drop_cnt         <= drop_cnt_next;
            overflow_pending <= (drop_cnt_next != '0);
        end
    end

    lpc_frame_shifter #(
        .FRAME_BYTES (FRAME_BYTES),
        .CNT_W       (CNT_W)
    ) u_shifter (
        .clk       (ext_clock),
        .rst_n     (lpc_reset),
        .load      (load),
        .load_data (load_data),
        .load_rem  (load_rem),
        .advance   (accept),
        .head      (head),
        .last      (last)
    );

    assign accept         = send && bus.uart_ready;
    // Gated by reset so the strobe stays low while reset holds the FSM in IDLE.
    assign bus.fifo_read  = rd_req && lpc_reset;
    assign bus.uart_valid = send;
    assign bus.uart_data  = head;
    assign busy           = (state != ST_IDLE);

endmodule
